// File: rtl/if_queue_pkg.sv
// Shared core constants: datapath width, the canonical NOP, and the
// default instruction-queue depth, plus the queue entry layout.
package if_queue_pkg;

    localparam int                CORE_XLEN     = 32;
    localparam logic [31:0]       CORE_NOP_INST = 32'h0000_0013;  // addi x0, x0, 0
    localparam int                IQ_DEPTH      = 4;

    // One queued fetch: PC in the upper half, instruction word in the lower.
    typedef struct packed {
        logic [CORE_XLEN-1:0] pc;
        logic [CORE_XLEN-1:0] inst;
    } iq_entry_t;

endpackage

// File: rtl/if_queue.sv
// Fetch-to-decode instruction queue. A circular buffer decouples the
// fetch stage from decode; a branch redirect empties it in one edge.
// Full/valid flags are decoded from registered count only, so the fetch
// stall never depends combinationally on decode's id_ready.
module if_queue
    import if_queue_pkg::*;
#(
    parameter int                   DEPTH    = IQ_DEPTH,
    parameter logic [CORE_XLEN-1:0] NOP_INST = CORE_NOP_INST
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CORE_XLEN-1:0] if_inst,
    input  logic [CORE_XLEN-1:0] if_pc,
    input  logic                 br_ctrl,
    input  logic                 id_ready,
    output logic                 pc_stall,
    output logic [CORE_XLEN-1:0] id_inst,
    output logic [CORE_XLEN-1:0] id_pc,
    output logic                 id_valid
);

    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    iq_entry_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          push;
    logic          pop;

    // Flags come straight off count. Because push is gated by pc_stall,
    // a full queue can only pop, and the stall clears on the next cycle.
    always_comb begin
        pc_stall = (count == CNT_FULL);
        id_valid = (count != '0);
        push     = !pc_stall && !br_ctrl;
        pop      = id_valid && id_ready && !br_ctrl;
    end

    // Head presentation: a NOP bubble with PC 0 whenever nothing is queued.
    always_comb begin
        id_inst = NOP_INST;
        id_pc   = '0;
        if (id_valid) begin
            id_inst = mem[rd_ptr].inst;
            id_pc   = mem[rd_ptr].pc;
        end
    end

    // Pointer/count state: reset beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (br_ctrl) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Entry storage is not reset; stale contents are masked by count.
    // Pushes are suppressed during reset so nothing lands mid-reset.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem[wr_ptr] <= '{pc: if_pc, inst: if_inst};
        end
    end

endmodule

// File: tb/tb_if_queue.sv
// Directed bench for if_queue (DEPTH=4). Fetch words are tagged as
// 32'hA000_0000 | pc so each expected id_inst is easy to write by hand.
module tb_if_queue;

    logic        clk;
    logic        rst;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        br_ctrl;
    logic        id_ready;
    logic        pc_stall;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_valid;

    int checks;
    int errors;

    if_queue #(.DEPTH(4), .NOP_INST(32'h0000_0013)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_inst  (if_inst),
        .if_pc    (if_pc),
        .br_ctrl  (br_ctrl),
        .id_ready (id_ready),
        .pc_stall (pc_stall),
        .id_inst  (id_inst),
        .id_pc    (id_pc),
        .id_valid (id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc);
        if_pc   = pc;
        if_inst = 32'hA000_0000 | pc;
    endtask

    task automatic clear();
        rst      = 1'b0;
        br_ctrl  = 1'b0;
        id_ready = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; br_ctrl = 1'b0; id_ready = 1'b0;
        fetch(32'h0);
        step();
        checks++;
        if ({pc_stall, id_valid} !== 2'b00) begin
            errors++; $display("FAIL reset_flags: stall/valid=%b required 00", {pc_stall, id_valid});
        end
        checks++;
        if (id_inst !== 32'h0000_0013) begin
            errors++; $display("FAIL reset_inst: got %h required 00000013", id_inst);
        end
        checks++;
        if (id_pc !== 32'h0) begin
            errors++; $display("FAIL reset_pc: got %h required 00000000", id_pc);
        end
        rst = 1'b1;
    endtask

    // Streaming fetch with decode always ready: head follows fetch by one edge.
    task automatic test_stream();
        logic [31:0] exp_pc;
        id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_pc = 32'(i * 4);
            fetch(exp_pc);
            step();
            checks++;
            if (id_valid !== 1'b1 || id_pc !== exp_pc || id_inst !== (32'hA000_0000 | exp_pc)) begin
                errors++;
                $display("FAIL stream_%0d: valid=%b pc=%h inst=%h required 1 %h %h",
                         i, id_valid, id_pc, id_inst, exp_pc, 32'hA000_0000 | exp_pc);
            end
        end
    endtask

    // Fill with decode stalled, hold the head, then a single pop from full.
    task automatic test_full_and_pop();
        clear();
        id_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fetch(32'(i * 4));
            step();
            checks++;
            if (pc_stall !== (i == 3) || id_pc !== 32'h0) begin
                errors++;
                $display("FAIL fill_%0d: stall=%b pc=%h required %b 00000000", i, pc_stall, id_pc, i == 3);
            end
        end
        fetch(32'h10);
        step();
        checks++;
        if (pc_stall !== 1'b1 || id_pc !== 32'h0 || id_inst !== 32'hA000_0000) begin
            errors++;
            $display("FAIL full_hold: stall=%b pc=%h inst=%h required 1 00000000 a0000000",
                     pc_stall, id_pc, id_inst);
        end
        // One pop from full: no push this cycle, stall drops after it.
        id_ready = 1'b1;
        step();
        checks++;
        if (pc_stall !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'h4) begin
            errors++;
            $display("FAIL pop_full: stall=%b valid=%b pc=%h required 0 1 00000004", pc_stall, id_valid, id_pc);
        end
        // The held 0x10 goes in now; exactly one free slot means full again.
        id_ready = 1'b0;
        step();
        checks++;
        if (pc_stall !== 1'b1 || id_pc !== 32'h4) begin
            errors++;
            $display("FAIL refill: stall=%b pc=%h required 1 00000004", pc_stall, id_pc);
        end
        id_ready = 1'b1;
        step();
        checks++;
        if (id_pc !== 32'h8 || id_inst !== 32'hA000_0008 || pc_stall !== 1'b0) begin
            errors++;
            $display("FAIL fifo_order: pc=%h inst=%h stall=%b required 00000008 a0000008 0",
                     id_pc, id_inst, pc_stall);
        end
        id_ready = 1'b0;
    endtask

    // Flush with three queued entries and decode ready.
    task automatic test_flush();
        clear();
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fetch(32'(i * 4));
            step();
        end
        br_ctrl  = 1'b1;
        id_ready = 1'b1;
        fetch(32'hC);
        step();
        checks++;
        if (id_valid !== 1'b0 || id_inst !== 32'h0000_0013 || id_pc !== 32'h0 || pc_stall !== 1'b0) begin
            errors++;
            $display("FAIL flush: valid=%b inst=%h pc=%h stall=%b required 0 00000013 00000000 0",
                     id_valid, id_inst, id_pc, pc_stall);
        end
        br_ctrl  = 1'b0;
        id_ready = 1'b0;
        fetch(32'h100);
        step();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_inst !== 32'hA000_0100) begin
            errors++;
            $display("FAIL post_flush: valid=%b pc=%h inst=%h required 1 00000100 a0000100",
                     id_valid, id_pc, id_inst);
        end
    endtask

    // Steady push+pop at occupancy one across two pointer wraps.
    task automatic test_wrap();
        logic [31:0] exp_pc;
        clear();
        id_ready = 1'b0;
        fetch(32'h0);
        step();
        id_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            exp_pc = 32'(k * 4);
            fetch(exp_pc);
            step();
            checks++;
            if (id_valid !== 1'b1 || id_pc !== exp_pc || id_inst !== (32'hA000_0000 | exp_pc) || pc_stall !== 1'b0) begin
                errors++;
                $display("FAIL wrap_%0d: valid=%b pc=%h inst=%h stall=%b required 1 %h %h 0",
                         k, id_valid, id_pc, id_inst, pc_stall, exp_pc, 32'hA000_0000 | exp_pc);
            end
        end
        // Occupancy must still be exactly one: three more pushes fill it.
        id_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            fetch(32'h200 + 32'(j * 4));
            step();
            checks++;
            if (pc_stall !== (j == 2) || id_pc !== 32'h28) begin
                errors++;
                $display("FAIL wrap_count_%0d: stall=%b pc=%h required %b 00000028", j, pc_stall, id_pc, j == 2);
            end
        end
    endtask

    // Reset on a full queue while a flush and a pop are also requested.
    task automatic test_reset_mid();
        rst      = 1'b0;
        br_ctrl  = 1'b1;
        id_ready = 1'b1;
        fetch(32'h300);
        step();
        checks++;
        if (pc_stall !== 1'b0 || id_valid !== 1'b0 || id_inst !== 32'h0000_0013 || id_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: stall=%b valid=%b inst=%h pc=%h required 0 0 00000013 00000000",
                     pc_stall, id_valid, id_inst, id_pc);
        end
        rst = 1'b1; br_ctrl = 1'b0; id_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_stream();
        test_full_and_pop();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_queue.md
IF_QUEUE -- requirements
Module: if_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of queue entries; power of two, minimum 2.
REQ-002 Parameter: NOP_INST, 32'h00000013, instruction presented to decode when the queue is empty.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-low.
REQ-005 if_inst  input  32  instruction fetched at if_pc; valid in every cycle in which pc_stall is low.
REQ-006 if_pc  input  32  PC of if_inst.
REQ-007 br_ctrl  input  1  branch/jump redirect; flushes all queued and in-flight instructions.
REQ-008 id_ready  input  1  decode stage accepts the head entry this cycle.
REQ-009 pc_stall  output  1  holds the fetch PC while the queue is full.
REQ-010 id_inst  output  32  head instruction; NOP_INST when empty.
REQ-011 id_pc  output  32  head PC; 32'h0 when empty.
REQ-012 id_valid  output  1  head entry is valid.

Function
REQ-013 Storage SHALL be a circular buffer of DEPTH entries of {pc[31:0], inst[31:0]}, with wr_ptr, rd_ptr and count[log2(DEPTH):0].
REQ-014 push = !pc_stall && !br_ctrl; on push, {if_pc, if_inst} SHALL be written at wr_ptr and wr_ptr SHALL increment modulo DEPTH.
REQ-015 pop = id_valid && id_ready && !br_ctrl; on pop, rd_ptr SHALL increment modulo DEPTH.
REQ-016 count SHALL become count+1 on push only, count-1 on pop only, and stay unchanged on simultaneous push and pop.
REQ-017 pc_stall SHALL equal (count == DEPTH), decoded from registered state only, with no combinational path from id_ready.
REQ-018 When full, a pop SHALL NOT be combined with a push in the same cycle; pc_stall drops in the following cycle.
REQ-019 id_valid SHALL equal (count != 0); id_inst and id_pc SHALL be driven from the entry at rd_ptr when valid, else NOP_INST and 0.
REQ-020 Latency: an instruction pushed at edge N SHALL appear at the head after edge N if the queue was empty at N; otherwise it appears in FIFO order.
REQ-021 Flush priority: when br_ctrl=1, the next edge SHALL set count=0 and wr_ptr=rd_ptr=0, and SHALL block push and pop regardless of id_ready.
REQ-022 The if_inst present during a br_ctrl cycle is wrong-path and SHALL be discarded.
REQ-023 Pointer wrap from DEPTH-1 to 0 SHALL NOT disturb ordering or count.
REQ-024 id_ready while empty SHALL have no effect.
REQ-025 A held head (id_valid=1, id_ready=0) SHALL keep id_inst and id_pc stable.

Reset
REQ-026 With rst=0 at a rising edge: count=0, wr_ptr=0, rd_ptr=0, so pc_stall=0, id_valid=0, id_inst=NOP_INST and id_pc=0.
REQ-027 Reset SHALL override br_ctrl, push and pop.
REQ-028 Entry storage SHALL NOT be reset.
REQ-029 Reset applied mid-operation SHALL discard all entries within one edge.

Structure
REQ-030 XLEN (32), NOP_INST and the default queue depth SHALL live in the shared core constants package.
REQ-031 The block SHALL be a single module with no sub-modules; it instantiates between stage_if and the decode stage.

Verification
REQ-032 Reset, then id_ready=1 with streaming fetch from pc 0x0 -> entry for pc 0x0 valid at head one edge after first push; id_pc steps 0x0, 0x4, 0x8 with no bubbles.
REQ-033 id_ready=0, four pushes of pc 0x0–0xC -> pc_stall=1 after the 4th edge; head stays pc 0x0; fifth if_inst not stored.
REQ-034 Full queue, then id_ready=1 for one cycle -> pc 0x0 popped, count=3, pc_stall=0 the next cycle, no push in the pop cycle.
REQ-035 Three entries queued, br_ctrl=1 with id_ready=1 -> next cycle id_valid=0, id_inst=32'h00000013, pc_stall=0; first post-flush push (br_addr 0x100) becomes the head.
REQ-036 Alternate push/pop for 10 cycles with DEPTH=4 -> pointers wrap twice, FIFO order preserved, count stays at 1.
REQ-037 rst=0 while the queue is full and br_ctrl=1 -> next cycle all outputs at reset values.
